arena_map_arbiter: RTL and testbench
====================================

Name: arena_map_arbiter

Overview:
- Owns the shared 10x10 arena map and bomb map (100 cells, 2-bit arena code + 2-bit bomb code per cell).
- Serialises write requests from three requesters onto a single write port: player A control, player B control, bomb timer.
- Runs an initialisation sweep that loads the default layout after reset or on restart.
- Exposes a combinational read port for VGA/render logic; removes multi-driver conflicts on the map.

Parameters:
- CELLS, 100, number of map cells (row*10+col).
- IDX_W, 7, cell index width.
- LOAD_LAYOUT, 1, 1 = init sweep writes default blocks/players; 0 = all-zero map.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- restart  in  1  single-cycle pulse: re-run init sweep
- game_state  in  2  0 = running; nonzero = game over (freeze)
- a_req  in  1  player A write request, held until granted
- a_idx  in  7  player A target cell
- a_we  in  2  bit0 writes arena code, bit1 writes bomb code
- a_arena  in  2  arena code to write
- a_bomb  in  2  bomb code to write
- b_req, b_idx, b_we, b_arena, b_bomb  in  1/7/2/2/2  player B, same as A
- t_req, t_idx, t_we, t_arena, t_bomb  in  1/7/2/2/2  bomb timer, same as A
- a_gnt, b_gnt, t_gnt  out  1  combinational grant; write commits on this clock edge
- init_done  out  1  high when map is valid and accepting writes
- err_idx  out  1  registered one-cycle pulse: a granted index was >= CELLS
- rd_idx  in  7  read address
- rd_arena  out  2  combinational arena code at rd_idx
- rd_bomb  out  2  combinational bomb code at rd_idx

Behaviour:
- Arena codes: 0 empty, 1 block, 2 player A, 3 player B. Bomb codes: 0 none; 1-3 are a countdown owned by the bomb timer.
- Reset: state = INIT, sweep pointer = 0, init_done = 0, all grants = 0, err_idx = 0, last_served = B (so A wins the first tie), storage = all zero.
- FSM states: INIT, RUN, FREEZE.
- INIT:
  - One cell per cycle, index 0..99.
  - Bomb code written 0.
  - Arena code from the default layout: 11 = 2, 88 = 3, blocks at 13, 17, 24, 32, 34, 38, 46, 51, 56, 57, 62, 63, 76, 84, else 0.
  - After index 99 is written: next state RUN, init_done = 1. Exactly 100 cycles from reset release.
  - No grants during INIT.
- RUN:
  - At most one grant per cycle.
  - t_req has fixed highest priority.
  - Between a_req and b_req: round-robin. When both are pending, grant the requester not equal to last_served. last_served updates on every player grant.
  - Sole player requester is granted immediately.
  - Granted write updates only the fields selected by we. we = 0 is granted as a no-op.
- Grant rules:
  - Grant is combinational from req, state and last_served.
  - Requester drops req after the edge where gnt = 1.
  - Ungranted requesters keep req and data stable.
- Index >= CELLS: request is granted, storage is unchanged, err_idx pulses the next cycle.
- FREEZE:
  - Entered from RUN when game_state != 0, evaluated each cycle.
  - Player requests get no grant. Timer requests are still granted so explosions finish.
  - Returns to RUN when game_state == 0.
- restart:
  - From any state: next state INIT, pointer = 0, init_done = 0 the next cycle.
  - An in-flight grant in the same cycle still commits, then is overwritten by the sweep.
- Reset mid-sweep: async return to the reset state. The sweep restarts from 0.
- Read port:
  - Returns current storage, so same-cycle read of a cell being written returns the old value.
  - rd_idx >= CELLS returns 0.
  - During INIT, reads return whatever has been swept so far.

Decomposition:
- Package bm_map_pkg: CELLS, IDX_W, arena code constants (EMPTY, BLOCK, PLAYER_A, PLAYER_B), default-layout function mapping idx to arena code, FSM state enum.
- Sub-module rr_pick2: two-requester round-robin with last_served register; the top adds timer priority and the state gate.

Test Plan:
- Reset release: after exactly 100 cycles init_done = 1; rd_idx = 11 gives rd_arena = 2, 88 gives 3, 13 gives 1, 0 gives 0; all rd_bomb = 0.
- a_req and b_req both held from the first RUN cycle, idx 20/30, we = 01, arena 2/3 → a_gnt in cycle 1, b_gnt in cycle 2; cells 20 = 2 and 30 = 3.
- t_req + a_req + b_req same cycle (t idx 45, we = 10, bomb 3) → only t_gnt; cell 45 bomb = 3 and arena unchanged; A is granted the next cycle.
- a_req idx 100 → a_gnt = 1, err_idx = 1 the following cycle, no cell changed.
- game_state = 2 with a_req and t_req pending → t_gnt only; a_req waits; a_gnt fires the first cycle after game_state returns to 0.
- restart pulse after writing cell 20 = 2 → init_done = 0 the next cycle; after 100 cycles cell 20 = 0 and init_done = 1. rst asserted mid-sweep → init_done = 0 immediately, full 100-cycle sweep repeats.

Source files
------------

// File: rtl/bm_map_pkg.sv
// Shared definitions for the arena/bomb map: geometry, cell codes, FSM states
// and the default arena layout loaded by the init sweep.
package bm_map_pkg;

  localparam int unsigned CELLS = 100;
  localparam int unsigned IDX_W = 7;

  localparam logic [1:0] EMPTY    = 2'd0;
  localparam logic [1:0] BLOCK    = 2'd1;
  localparam logic [1:0] PLAYER_A = 2'd2;
  localparam logic [1:0] PLAYER_B = 2'd3;

  typedef enum logic [1:0] {
    StInit,
    StRun,
    StFreeze
  } state_e;

  function automatic logic [1:0] default_arena(input logic [IDX_W-1:0] idx);
    logic [1:0] code;
    case (idx)
      7'd11:   code = PLAYER_A;
      7'd88:   code = PLAYER_B;
      7'd13, 7'd17, 7'd24, 7'd32, 7'd34, 7'd38, 7'd46,
      7'd51, 7'd56, 7'd57, 7'd62, 7'd63, 7'd76, 7'd84:
               code = BLOCK;
      default: code = EMPTY;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/arena_map_arbiter_if.sv
// Request/grant, control and render-read signals of the map arbiter.
interface arena_map_arbiter_if;
  import bm_map_pkg::*;

  logic             restart;
  logic [1:0]       game_state;
  logic             a_req, b_req, t_req;
  logic [IDX_W-1:0] a_idx, b_idx, t_idx;
  logic [1:0]       a_we, b_we, t_we;
  logic [1:0]       a_arena, b_arena, t_arena;
  logic [1:0]       a_bomb, b_bomb, t_bomb;
  logic             a_gnt, b_gnt, t_gnt;
  logic             init_done;
  logic             err_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [1:0]       rd_arena, rd_bomb;

  modport master (
    output restart, game_state,
    output a_req, a_idx, a_we, a_arena, a_bomb,
    output b_req, b_idx, b_we, b_arena, b_bomb,
    output t_req, t_idx, t_we, t_arena, t_bomb,
    output rd_idx,
    input  a_gnt, b_gnt, t_gnt, init_done, err_idx, rd_arena, rd_bomb
  );

  modport slave (
    input  restart, game_state,
    input  a_req, a_idx, a_we, a_arena, a_bomb,
    input  b_req, b_idx, b_we, b_arena, b_bomb,
    input  t_req, t_idx, t_we, t_arena, t_bomb,
    input  rd_idx,
    output a_gnt, b_gnt, t_gnt, init_done, err_idx, rd_arena, rd_bomb
  );
endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie, grants the side not served last.
module rr_pick2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic last_b_q, last_b_d;  // 1 = B was served last

  always_comb begin
    gnt_a    = en && req_a && (!req_b || last_b_q);
    gnt_b    = en && req_b && (!req_a || !last_b_q);
    last_b_d = last_b_q;
    if (gnt_a) begin
      last_b_d = 1'b0;
    end else if (gnt_b) begin
      last_b_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end

endmodule

// File: rtl/arena_map_arbiter.sv
// Single owner of the arena/bomb map: init sweep, prioritised write port for
// two players and the bomb timer, and a combinational render read port.
module arena_map_arbiter
  import bm_map_pkg::*;
#(
  parameter int unsigned LOAD_LAYOUT = 1
) (
  input logic                clk,
  input logic                rst,
  arena_map_arbiter_if.slave bus
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [1:0]       arena_q [CELLS];
  logic [1:0]       bomb_q  [CELLS];
  logic             err_q;
  logic             play_en, init_done;
  logic             a_gnt, b_gnt, t_gnt;
  logic             wr_en, wr_ok;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       wr_we, wr_arena, wr_bomb;
  logic [1:0]       sweep_arena;
  logic             rd_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StInit;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StInit: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == IDX_W'(CELLS - 1)) begin
          state_d = StRun;
          ptr_d   = '0;
        end
      end
      StRun:    if (bus.game_state != 2'd0) state_d = StFreeze;
      StFreeze: if (bus.game_state == 2'd0) state_d = StRun;
      default:  state_d = StInit;
    endcase
    // Restart wins over every transition; any grant this cycle still commits.
    if (bus.restart) begin
      state_d = StInit;
      ptr_d   = '0;
    end
  end

  // Timer keeps running through FREEZE so pending explosions can finish.
  always_comb begin
    init_done = (state_q != StInit);
    t_gnt     = bus.t_req && (state_q != StInit);
    play_en   = (state_q == StRun) && !bus.t_req;
  end

  rr_pick2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .en    (play_en),
    .req_a (bus.a_req),
    .req_b (bus.b_req),
    .gnt_a (a_gnt),
    .gnt_b (b_gnt)
  );

  always_comb begin
    wr_en    = t_gnt || a_gnt || b_gnt;
    wr_idx   = bus.b_idx;
    wr_we    = bus.b_we;
    wr_arena = bus.b_arena;
    wr_bomb  = bus.b_bomb;
    if (t_gnt) begin
      wr_idx   = bus.t_idx;
      wr_we    = bus.t_we;
      wr_arena = bus.t_arena;
      wr_bomb  = bus.t_bomb;
    end else if (a_gnt) begin
      wr_idx   = bus.a_idx;
      wr_we    = bus.a_we;
      wr_arena = bus.a_arena;
      wr_bomb  = bus.a_bomb;
    end
    wr_ok       = wr_en && (wr_idx < IDX_W'(CELLS));
    sweep_arena = (LOAD_LAYOUT != 0) ? default_arena(ptr_q) : EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CELLS; i++) begin
        arena_q[i] <= EMPTY;
        bomb_q[i]  <= 2'd0;
      end
      err_q <= 1'b0;
    end else begin
      err_q <= wr_en && !wr_ok;
      if (state_q == StInit) begin
        arena_q[ptr_q] <= sweep_arena;
        bomb_q[ptr_q]  <= 2'd0;
      end else if (wr_ok) begin
        if (wr_we[0]) arena_q[wr_idx] <= wr_arena;
        if (wr_we[1]) bomb_q[wr_idx]  <= wr_bomb;
      end
    end
  end

  always_comb begin
    rd_ok = (bus.rd_idx < IDX_W'(CELLS));
  end

  assign bus.rd_arena  = rd_ok ? arena_q[bus.rd_idx] : EMPTY;
  assign bus.rd_bomb   = rd_ok ? bomb_q[bus.rd_idx] : 2'd0;
  assign bus.a_gnt     = a_gnt;
  assign bus.b_gnt     = b_gnt;
  assign bus.t_gnt     = t_gnt;
  assign bus.init_done = init_done;
  assign bus.err_idx   = err_q;

endmodule

// File: tb/tb_arena_map_arbiter.sv
// Randomised and directed stimulus for arena_map_arbiter, checked against a
// cycle-level behavioural model of the map and the grant rules.
module tb_arena_map_arbiter;

  logic clk;
  logic rst;
  arena_map_arbiter_if bus ();

  arena_map_arbiter #(
    .LOAD_LAYOUT (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Requester agents: 0 = player A, 1 = player B, 2 = bomb timer
  logic       pend [3];
  logic [6:0] r_idx [3];
  logic [1:0] r_we [3];
  logic [1:0] r_ar [3];
  logic [1:0] r_bo [3];
  logic [1:0] gs;
  logic       rs;
  logic [6:0] rd;

  // Model: phase 0 = sweeping, 1 = running, 2 = frozen
  int   m_arena [100];
  int   m_bomb  [100];
  int   m_phase;
  int   m_sweep;
  int   m_last;  // 0 = A served last, 1 = B
  logic m_err;

  int blocks [14] = '{13, 17, 24, 32, 34, 38, 46, 51, 56, 57, 62, 63, 76, 84};

  function automatic int layout(input int i);
    if (i == 11) return 2;
    if (i == 88) return 3;
    foreach (blocks[k]) if (blocks[k] == i) return 1;
    return 0;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    bus.a_req = pend[0]; bus.a_idx = r_idx[0]; bus.a_we = r_we[0];
    bus.a_arena = r_ar[0]; bus.a_bomb = r_bo[0];
    bus.b_req = pend[1]; bus.b_idx = r_idx[1]; bus.b_we = r_we[1];
    bus.b_arena = r_ar[1]; bus.b_bomb = r_bo[1];
    bus.t_req = pend[2]; bus.t_idx = r_idx[2]; bus.t_we = r_we[2];
    bus.t_arena = r_ar[2]; bus.t_bomb = r_bo[2];
    bus.game_state = gs;
    bus.restart = rs;
    bus.rd_idx = rd;
  endtask

  task automatic set_req(input int r, input int idx, input int we, input int ar, input int bo);
    pend[r]  = 1'b1;
    r_idx[r] = 7'(idx);
    r_we[r]  = 2'(we);
    r_ar[r]  = 2'(ar);
    r_bo[r]  = 2'(bo);
  endtask

  // Called at posedge+1: checks this cycle's outputs, then advances one clock.
  task automatic step();
    int g;
    drive();
    #1;
    g = -1;
    if (m_phase != 0 && pend[2]) g = 2;
    else if (m_phase == 1) begin
      if (pend[0] && pend[1]) g = (m_last == 1) ? 0 : 1;
      else if (pend[0]) g = 0;
      else if (pend[1]) g = 1;
    end
    check_eq("a_gnt", 32'(bus.a_gnt), 32'(g == 0));
    check_eq("b_gnt", 32'(bus.b_gnt), 32'(g == 1));
    check_eq("t_gnt", 32'(bus.t_gnt), 32'(g == 2));
    check_eq("init_done", 32'(bus.init_done), 32'(m_phase != 0));
    check_eq("err_idx", 32'(bus.err_idx), 32'(m_err));
    check_eq("rd_arena", 32'(bus.rd_arena), (rd < 100) ? m_arena[rd] : 0);
    check_eq("rd_bomb", 32'(bus.rd_bomb), (rd < 100) ? m_bomb[rd] : 0);
    @(posedge clk);
    m_err = 1'b0;
    if (g >= 0) begin
      if (r_idx[g] >= 100) m_err = 1'b1;
      else begin
        if (r_we[g][0]) m_arena[r_idx[g]] = r_ar[g];
        if (r_we[g][1]) m_bomb[r_idx[g]] = r_bo[g];
      end
      if (g < 2) m_last = g;
      pend[g] = 1'b0;
    end
    case (m_phase)
      0: begin
        m_arena[m_sweep] = layout(m_sweep);
        m_bomb[m_sweep]  = 0;
        m_sweep++;
        if (m_sweep == 100) m_phase = 1;
      end
      1: if (gs != 0) m_phase = 2;
      default: if (gs == 0) m_phase = 1;
    endcase
    if (rs) begin
      m_phase = 0;
      m_sweep = 0;
    end
    rs = 1'b0;
    #1;
  endtask

  // Asynchronous reset applied mid-cycle; released one clock later.
  task automatic do_reset();
    foreach (pend[r]) pend[r] = 1'b0;
    rs = 1'b0;
    gs = 2'd0;
    rd = 7'd11;
    rst = 1'b1;
    drive();
    #1;
    check_eq("rst_init_done", 32'(bus.init_done), 0);
    check_eq("rst_err_idx", 32'(bus.err_idx), 0);
    check_eq("rst_rd_arena", 32'(bus.rd_arena), 0);
    foreach (m_arena[i]) begin
      m_arena[i] = 0;
      m_bomb[i]  = 0;
    end
    m_phase = 0;
    m_sweep = 0;
    m_last  = 1;
    m_err   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic read_expect(input string tag, input int idx, input int ar, input int bo);
    rd = 7'(idx);
    drive();
    #1;
    check_eq({tag, "_arena"}, 32'(bus.rd_arena), ar);
    check_eq({tag, "_bomb"}, 32'(bus.rd_bomb), bo);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    foreach (pend[r]) begin
      pend[r] = 1'b0; r_idx[r] = '0; r_we[r] = '0; r_ar[r] = '0; r_bo[r] = '0;
    end
    rst = 1'b1;
    drive();
    @(posedge clk);
    #1;
    do_reset();

    // Initial sweep: init_done must rise after exactly 100 clocks
    for (int i = 0; i < 100; i++) step();
    check_eq("sweep_done", 32'(bus.init_done), 1);
    read_expect("rd11", 11, 2, 0);
    read_expect("rd88", 88, 3, 0);
    read_expect("rd13", 13, 1, 0);
    read_expect("rd0", 0, 0, 0);

    // A/B tie: A first (B counted as served last after reset)
    set_req(0, 20, 1, 2, 0);
    set_req(1, 30, 1, 3, 0);
    step();
    step();
    read_expect("tie20", 20, 2, 0);
    read_expect("tie30", 30, 3, 0);

    // Timer beats both players; bomb-only write keeps arena code
    set_req(2, 45, 2, 1, 3);
    set_req(0, 21, 1, 2, 0);
    set_req(1, 31, 1, 3, 0);
    step();
    read_expect("t45", 45, 0, 3);
    step();
    step();

    // Out-of-range index: granted, no write, err pulse next cycle
    set_req(0, 100, 3, 1, 1);
    step();
    check_eq("err_pulse", 32'(bus.err_idx), 1);
    step();

    // Freeze: timer still served, player waits until game_state clears
    gs = 2'd2;
    step();
    set_req(0, 22, 1, 2, 0);
    set_req(2, 23, 2, 0, 2);
    step();
    step();
    check_eq("frz_a_waits", 32'(pend[0]), 1);
    gs = 2'd0;
    step();
    step();
    check_eq("frz_a_served", 32'(pend[0]), 0);

    // Restart wipes cell 20 and re-runs the whole sweep
    rs = 1'b1;
    step();
    check_eq("restart_low", 32'(bus.init_done), 0);
    for (int i = 0; i < 100; i++) step();
    check_eq("restart_done", 32'(bus.init_done), 1);
    read_expect("rs20", 20, 0, 0);

    // Reset in the middle of a sweep
    rs = 1'b1;
    step();
    for (int i = 0; i < 40; i++) step();
    do_reset();
    for (int i = 0; i < 99; i++) step();
    check_eq("resweep_not_yet", 32'(bus.init_done), 0);
    step();
    check_eq("resweep_done", 32'(bus.init_done), 1);

    // Random traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int r = 0; r < 3; r++) begin
        if (!pend[r] && ($urandom_range(0, (r == 2) ? 3 : 1) == 0)) begin
          set_req(r, ($urandom_range(0, 9) == 0) ? $urandom_range(100, 127)
                                                  : $urandom_range(0, 99),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end
      end
      if ($urandom_range(0, 29) == 0) gs = (gs != 0) ? 2'd0 : 2'($urandom_range(1, 3));
      if ($urandom_range(0, 399) == 0) rs = 1'b1;
      rd = 7'($urandom_range(0, 127));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
